// File: rtl/dlyprog_line.sv
// ============================================================================
// Module   : dlyprog_line
// Brief    : WIDTH-bit, DEPTH-stage shift-register delay line with a run-time
//            selectable tap (0..DEPTH enabled cycles) and a tap-valid flag.
//            Optional macro DLYPROG_LINE_ZMASK_EN zeroes Z while VLD is low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dlyprog_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int SW   = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [SW-1:0]    SEL,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Z,
    output logic             VLD
);

    localparam logic [SW-1:0] c_depth = SW'(DEPTH);
    localparam logic [SW-1:0] c_one   = SW'(1);

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [SW-1:0]    r_sel_q;
    logic [SW-1:0]    r_fill;

    logic [SW-1:0]    w_sel_eff;
    logic [WIDTH-1:0] w_tap;
    logic [WIDTH-1:0] w_raw;
    logic             w_vld;

    assign w_sel_eff = (SEL > c_depth) ? c_depth : SEL;

    // Data path: stages only move on enabled edges and are never flushed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else if (EN) begin
            r_stage[0] <= I;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    // A select change restarts the fill count; the shift on that same edge
    // already counts as the first genuinely delayed sample.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sel_q <= c_depth;
            r_fill  <= '0;
        end else begin
            r_sel_q <= w_sel_eff;
            if (w_sel_eff != r_sel_q) begin
                r_fill <= EN ? c_one : '0;
            end else if (EN && (r_fill < c_depth)) begin
                r_fill <= r_fill + c_one;
            end
        end
    end

    always_comb begin
        w_tap = r_stage[0];
        for (int k = 0; k < DEPTH; k++) begin
            if (r_sel_q == SW'(k + 1)) begin
                w_tap = r_stage[k];
            end
        end
    end

    assign w_raw = (r_sel_q == '0) ? I : w_tap;
    assign w_vld = (r_fill >= r_sel_q);
    assign VLD   = w_vld;

`ifdef DLYPROG_LINE_ZMASK_EN
    assign Z = w_vld ? w_raw : '0;
`else
    assign Z = w_raw;
`endif

endmodule

`default_nettype wire
